control_store: RTL

Microcode control store for the MIC-1 core. It holds up to 512 microinstructions of 36 bits each, loaded through a valid/ready port. In run mode it returns the registered MIR for the MPC that `controlpath` presents, closing the MPC → MIR loop. It is the responder on the MPC/MIR interface: `controlpath` issues addresses and this block answers with microinstructions.

---
 rtl/control_store.sv | 123 ++++++++++++
 1 files changed

// File: rtl/control_store.sv
// control_store: MIC-1 microcode store with a valid/ready load port and a registered MPC->MIR fetch.
// Define CS_PARITY_EN to store an even-parity bit per word and check it on every fetch.
module control_store #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 36,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] MPC,
  input  logic              run,
  input  logic              reload,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_par,
  input  logic              ld_last,
  output logic [DATA_W-1:0] MIR,
  output logic [ADDR_W:0]   loaded,
  output logic              par_err
);

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [ADDR_W:0] L_MAX = (ADDR_W+1)'(DEPTH);

`ifdef CS_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_mir;
  logic [ADDR_W:0]   r_loaded;
  logic [MW-1:0]     r_mem [DEPTH];

  logic              w_load;
  logic              w_acc;
  logic              w_fetch;
  logic              w_rl;
  logic [MW-1:0]     w_wdata;
  logic [MW-1:0]     w_rd;
  logic              w_perr;

  assign w_load  = (r_state == S_LOAD);
  assign w_acc   = w_load && ld_valid;
  assign w_rl    = !w_load && reload;
  assign w_fetch = !w_load && !reload && run;
  assign w_rd    = r_mem[MPC];

`ifdef CS_PARITY_EN
  assign w_wdata = {ld_par, ld_data};
  // Stored word plus its parity bit must XOR to zero.
  assign w_perr  = ^w_rd;
`else
  logic w_unused_par;
  assign w_unused_par = ld_par;
  assign w_wdata = ld_data;
  assign w_perr  = 1'b0;
`endif

  assign ld_ready = w_load;
  assign MIR      = r_mir;
  assign loaded   = r_loaded;

  // Storage array; contents survive reset and are only written in LOAD.
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[ld_addr] <= w_wdata;
  end

  // LOAD/RUN sequencing: ld_last beat enters RUN, reload returns to LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOAD;
    end else if (w_acc && ld_last) begin
      r_state <= S_RUN;
    end else if (w_rl) begin
      r_state <= S_LOAD;
    end
  end

  // Count accepted beats since entering LOAD, saturating at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_loaded <= '0;
    end else if (w_rl) begin
      r_loaded <= '0;
    end else if (w_acc && r_loaded != L_MAX) begin
      r_loaded <= r_loaded + 1'b1;
    end
  end

  // MIR: NOP in LOAD or on reload, fetched word on run, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mir <= '0;
    end else if (w_load || w_rl) begin
      r_mir <= '0;
    end else if (w_fetch) begin
      r_mir <= w_perr ? '0 : w_rd[DATA_W-1:0];
    end
  end

`ifdef CS_PARITY_EN
  logic r_perr;
  assign par_err = r_perr;

  // Sticky fetch parity error; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perr <= 1'b0;
    end else if (w_fetch && w_perr) begin
      r_perr <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule
